// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: access-size encoding and
// the zeroed (bubble) values of the EX/MEM and MEM/WB pipeline registers.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              rf_enable;
    logic              load;
    logic              load_store;
    logic              size;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_W-1:0]  rw;
    logic [DATA_W-1:0] pw;
    logic              le;
    logic              misalign;
  } mem_wb_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '0;
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_data_ram.sv
// Byte-addressed big-endian data RAM: combinational read, clocked write,
// word or byte access selected by size.
module data_ram
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic              size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);

  logic [7:0] mem [0:DEPTH-1];

  logic [ADDR_W-1:0] addr1_c;
  logic [ADDR_W-1:0] addr2_c;
  logic [ADDR_W-1:0] addr3_c;

  assign addr1_c = addr + ADDR_W'(1);
  assign addr2_c = addr + ADDR_W'(2);
  assign addr3_c = addr + ADDR_W'(3);

  // Most significant byte lives at the lowest address.
  always_ff @(posedge clk) begin
    if (we) begin
      if (size == SIZE_BYTE) begin
        mem[addr] <= wdata[7:0];
      end else begin
        mem[addr]    <= wdata[31:24];
        mem[addr1_c] <= wdata[23:16];
        mem[addr2_c] <= wdata[15:8];
        mem[addr3_c] <= wdata[7:0];
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (size == SIZE_BYTE) begin
      rdata_c = {24'h000000, mem[addr]};
    end else begin
      rdata_c = {mem[addr], mem[addr1_c], mem[addr2_c], mem[addr3_c]};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, data RAM access with alignment
// checking, and MEM/WB register driving the register-file write port.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EX_flush,
  input  logic [DATA_W-1:0] EX_result,
  input  logic [DATA_W-1:0] EX_store_data,
  input  logic [REG_W-1:0]  EX_Rd,
  input  logic              EX_RF_enable,
  input  logic              EX_load_instr,
  input  logic              EX_load_store_instr,
  input  logic              EX_size,
  output logic [REG_W-1:0]  MEM_Rd,
  output logic              MEM_RF_enable,
  output logic              MEM_MemRead,
  output logic [DATA_W-1:0] jump_MEM,
  output logic [REG_W-1:0]  RW,
  output logic [DATA_W-1:0] PW,
  output logic              LE,
  output logic              misalign
);

  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  logic [ADDR_W-1:0] addr_c;
  logic              is_load_c;
  logic              is_store_c;
  logic              misaligned_c;
  logic              ram_we_c;
  logic [DATA_W-1:0] ram_rdata_c;

  // EX/MEM capture; a flush turns the incoming instruction into a bubble.
  always_comb begin
    ex_mem_d = EX_MEM_BUBBLE;
    if (!EX_flush) begin
      ex_mem_d.result     = EX_result;
      ex_mem_d.store_data = EX_store_data;
      ex_mem_d.rd         = EX_Rd;
      ex_mem_d.rf_enable  = EX_RF_enable;
      ex_mem_d.load       = EX_load_instr;
      ex_mem_d.load_store = EX_load_store_instr;
      ex_mem_d.size       = EX_size;
    end
  end

  assign addr_c       = ex_mem_q.result[ADDR_W-1:0];
  assign is_load_c    = ex_mem_q.load_store & ex_mem_q.load;
  assign is_store_c   = ex_mem_q.load_store & ~ex_mem_q.load;
  assign misaligned_c = ex_mem_q.load_store & (ex_mem_q.size == SIZE_WORD)
                        & (addr_c[1:0] != 2'b00);
  // A store caught by reset at its commit edge is dropped.
  assign ram_we_c     = reset & is_store_c & ~misaligned_c;

  data_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we_c),
    .size    (ex_mem_q.size),
    .addr    (addr_c),
    .wdata   (ex_mem_q.store_data),
    .rdata_c (ram_rdata_c)
  );

  always_comb begin
    mem_wb_d          = MEM_WB_BUBBLE;
    mem_wb_d.rw       = ex_mem_q.rd;
    mem_wb_d.misalign = misaligned_c;
    mem_wb_d.le       = ex_mem_q.rf_enable & ~is_store_c
                        & ~(is_load_c & misaligned_c);
    if (is_load_c) begin
      mem_wb_d.pw = misaligned_c ? '0 : ram_rdata_c;
    end else begin
      mem_wb_d.pw = ex_mem_q.result;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_mem_q <= EX_MEM_BUBBLE;
      mem_wb_q <= MEM_WB_BUBBLE;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  assign MEM_Rd        = ex_mem_q.rd;
  assign MEM_RF_enable = ex_mem_q.rf_enable;
  assign MEM_MemRead   = is_load_c;
  assign jump_MEM      = ex_mem_q.result;
  assign RW            = mem_wb_q.rw;
  assign PW            = mem_wb_q.pw;
  assign LE            = mem_wb_q.le;
  assign misalign      = mem_wb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a byte-array/instruction model predicts the
// MEM and WB outputs every cycle, plus literal checks from hand calculation.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        EX_flush;
  logic [31:0] EX_result;
  logic [31:0] EX_store_data;
  logic [3:0]  EX_Rd;
  logic        EX_RF_enable;
  logic        EX_load_instr;
  logic        EX_load_store_instr;
  logic        EX_size;
  logic [3:0]  MEM_Rd;
  logic        MEM_RF_enable;
  logic        MEM_MemRead;
  logic [31:0] jump_MEM;
  logic [3:0]  RW;
  logic [31:0] PW;
  logic        LE;
  logic        misalign;

  mem_stage #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk                 (clk),
    .reset               (reset),
    .EX_flush            (EX_flush),
    .EX_result           (EX_result),
    .EX_store_data       (EX_store_data),
    .EX_Rd               (EX_Rd),
    .EX_RF_enable        (EX_RF_enable),
    .EX_load_instr       (EX_load_instr),
    .EX_load_store_instr (EX_load_store_instr),
    .EX_size             (EX_size),
    .MEM_Rd              (MEM_Rd),
    .MEM_RF_enable       (MEM_RF_enable),
    .MEM_MemRead         (MEM_MemRead),
    .jump_MEM            (jump_MEM),
    .RW                  (RW),
    .PW                  (PW),
    .LE                  (LE),
    .misalign            (misalign)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: instruction sitting in MEM, expected WB outputs, RAM byte image.
  typedef struct {
    bit          known;
    bit          rf;
    bit          ld;
    bit          ls;
    bit          sz;
    logic [31:0] res;
    logic [31:0] sd;
    logic [3:0]  rd;
  } ins_t;

  ins_t        m_mem;
  bit          w_known, w_pw_chk, w_le, w_mis;
  logic [3:0]  w_rw;
  logic [31:0] w_pw;
  logic [7:0]  mm [0:255];

  function automatic logic [7:0] pre(input int i);
    return 8'((i * 7 + 3) % 256);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a, input bit byte_acc);
    logic [7:0] b0, b1, b2, b3;
    b0 = mm[a];
    b1 = mm[8'(a + 8'd1)];
    b2 = mm[8'(a + 8'd2)];
    b3 = mm[8'(a + 8'd3)];
    if (byte_acc) return {24'h0, b0};
    return (32'(b0) << 24) | (32'(b1) << 16) | (32'(b2) << 8) | 32'(b3);
  endfunction

  // Drive one EX slot, let the edge happen, advance the model to match.
  task automatic issue(input bit fl, input bit rs, input logic [31:0] res, input logic [31:0] sd,
                       input logic [3:0] rd, input bit rf, input bit ld, input bit ls, input bit sz);
    logic [7:0] a;
    bit         mis, st, ldi;
    EX_flush = fl; reset = rs; EX_result = res; EX_store_data = sd; EX_Rd = rd;
    EX_RF_enable = rf; EX_load_instr = ld; EX_load_store_instr = ls; EX_size = sz;
    @(posedge clk);
    if (!rs) begin
      m_mem = '{known: 1'b1, rf: 1'b0, ld: 1'b0, ls: 1'b0, sz: 1'b0, res: 32'h0, sd: 32'h0, rd: 4'h0};
      w_known = 1'b1; w_pw_chk = 1'b1; w_rw = 4'h0; w_pw = 32'h0; w_le = 1'b0; w_mis = 1'b0;
    end else begin
      a   = m_mem.res[7:0];
      mis = m_mem.ls && !m_mem.sz && (a % 4 != 0);
      st  = m_mem.ls && !m_mem.ld;
      ldi = m_mem.ls && m_mem.ld;
      w_known  = m_mem.known;
      w_rw     = m_mem.rd;
      w_mis    = mis;
      w_le     = m_mem.rf && !st && !(ldi && mis);
      w_pw     = ldi ? (mis ? 32'h0 : model_read(a, m_mem.sz)) : m_mem.res;
      w_pw_chk = m_mem.known && (ldi || w_le);
      if (st && !mis) begin
        if (m_mem.sz) mm[a] = m_mem.sd[7:0];
        else for (int k = 0; k < 4; k++) mm[8'(a + 8'(k))] = 8'(m_mem.sd >> (24 - 8 * k));
      end
      if (fl) m_mem = '{known: 1'b0, rf: 1'b0, ld: 1'b0, ls: 1'b0, sz: 1'b0, res: 32'h0, sd: 32'h0, rd: 4'h0};
      else    m_mem = '{known: 1'b1, rf: rf, ld: ld, ls: ls, sz: sz, res: res, sd: sd, rd: rd};
    end
    #1;
  endtask

  task automatic nop();
    issue(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_rf_enable", 32'(MEM_RF_enable), 32'(m_mem.rf));
      check("mem_memread", 32'(MEM_MemRead), 32'(m_mem.ls && m_mem.ld));
      check("le", 32'(LE), 32'(w_le));
      check("misalign", 32'(misalign), 32'(w_mis));
      if (m_mem.known) begin
        check("mem_rd", 32'(MEM_Rd), 32'(m_mem.rd));
        check("jump_mem", jump_MEM, m_mem.res);
      end
      if (w_known) check("rw", 32'(RW), 32'(w_rw));
      if (w_pw_chk) check("pw", PW, w_pw);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      dut.u_ram.mem[i] = pre(i);
      mm[i] = pre(i);
    end
    dut.u_ram.mem[8'h10] = 8'hAB; mm[8'h10] = 8'hAB;
    dut.u_ram.mem[8'hFF] = 8'h5A; mm[8'hFF] = 8'h5A;

    // Reset held for two edges with a load presented in EX
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h7, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_memread", 32'(MEM_MemRead), 32'h0);
    check("rst_mem_rd", 32'(MEM_Rd), 32'h0);
    check("rst_jump", jump_MEM, 32'h0);
    check("rst_rw", 32'(RW), 32'h0);
    check("rst_pw", PW, 32'h0);
    check("rst_le", 32'(LE), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    check("rst_ram_keep", 32'(dut.u_ram.mem[8'h10]), 32'hAB);
    chk_en = 1'b1;

    // Word store then load of the same address
    issue(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 32'h20, 32'h0, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0);
    check("str_b0", 32'(dut.u_ram.mem[8'h20]), 32'hDE);
    check("str_b1", 32'(dut.u_ram.mem[8'h21]), 32'hAD);
    check("str_b2", 32'(dut.u_ram.mem[8'h22]), 32'hBE);
    check("str_b3", 32'(dut.u_ram.mem[8'h23]), 32'hEF);
    nop();
    check("ldr_rw", 32'(RW), 32'h3);
    check("ldr_pw", PW, 32'hDEADBEEF);
    check("ldr_le", 32'(LE), 32'h1);

    // Byte store, byte load, word read-back
    issue(1'b0, 1'b1, 32'h21, 32'h123456C5, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 1'b1, 32'h21, 32'h0, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1);
    check("strb_byte", 32'(dut.u_ram.mem[8'h21]), 32'hC5);
    issue(1'b0, 1'b1, 32'h20, 32'h0, 4'h6, 1'b1, 1'b1, 1'b1, 1'b0);
    check("ldrb_pw", PW, 32'h000000C5);
    nop();
    check("ldr_after_strb", PW, 32'hDEC5BEEF);

    // Misaligned load and store
    issue(1'b0, 1'b1, 32'h22, 32'h0, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 32'h23, 32'h11223344, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mis_ld_flag", 32'(misalign), 32'h1);
    check("mis_ld_le", 32'(LE), 32'h0);
    check("mis_ld_pw", PW, 32'h0);
    nop();
    nop();
    check("mis_clear", 32'(misalign), 32'h0);
    check("mis_st_keep", {dut.u_ram.mem[8'h20], dut.u_ram.mem[8'h21],
                          dut.u_ram.mem[8'h22], dut.u_ram.mem[8'h23]}, 32'hDEC5BEEF);

    // Flushed store, then load hazard visibility
    issue(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    nop();
    nop();
    check("flush_ram_keep", 32'(dut.u_ram.mem[8'h30]), 32'(pre(8'h30)));
    check("flush_le", 32'(LE), 32'h0);
    issue(1'b0, 1'b1, 32'h40, 32'h0, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0);
    check("haz_memread", 32'(MEM_MemRead), 32'h1);
    check("haz_rd", 32'(MEM_Rd), 32'h5);
    nop();
    check("haz_memread_drop", 32'(MEM_MemRead), 32'h0);

    // ALU passthrough, then wrapped byte load
    issue(1'b0, 1'b1, 32'h00000107, 32'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("alu_jump", jump_MEM, 32'h107);
    issue(1'b0, 1'b1, 32'h000001FF, 32'h0, 4'h9, 1'b1, 1'b1, 1'b1, 1'b1);
    check("alu_pw", PW, 32'h107);
    check("alu_le", 32'(LE), 32'h1);
    check("alu_rw", 32'(RW), 32'h2);
    nop();
    check("wrap_pw", PW, 32'h5A);

    // A few more model-checked accesses over a range of addresses
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, 1'b1, 32'(8'h80 + 4 * i), 32'h01020304 * (i + 1), 4'h1, 1'b0, 1'b0, 1'b1, (i % 2) == 1);
      issue(1'b0, 1'b1, 32'(8'h80 + 4 * i), 32'h0, 4'(i + 10), 1'b1, 1'b1, 1'b1, 1'b0);
    end
    nop();

    // Reset lands while a store is in MEM; the store must be dropped
    issue(1'b0, 1'b1, 32'h44, 32'h77777777, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 32'h48, 32'h0, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0);
    nop();
    check("rst_st_drop", 32'(dut.u_ram.mem[8'h44]), 32'(pre(8'h44)));
    check("rst_mid_le", 32'(LE), 32'h0);
    nop();
    nop();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the ARM pipeline, directly downstream of the EX stage.
- Contains the EX/MEM pipeline register, a 256-byte big-endian data RAM, and the MEM/WB pipeline register.
- Consumes the ALU result (address), store data and control bits from EX.
- Produces the MEM-stage forwarding value and hazard signals, plus the write-back port (RW/PW/LE) for the register file.

Parameters:
- ADDR_W, 8, data RAM byte-address width.
- DEPTH, 256, data RAM size in bytes; must equal 2**ADDR_W.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- EX_flush  in  1  converts the EX/MEM capture into a bubble.
- EX_result  in  32  ALU result: memory address for load/store, writeback value otherwise.
- EX_store_data  in  32  store data (forwarded PD value).
- EX_Rd  in  4  destination register.
- EX_RF_enable  in  1  instruction writes the register file.
- EX_load_instr  in  1  1 = load, 0 = store (meaningful only with EX_load_store_instr).
- EX_load_store_instr  in  1  memory instruction.
- EX_size  in  1  1 = byte, 0 = word.
- MEM_Rd  out  4  EX/MEM destination, to HazardUnit.
- MEM_RF_enable  out  1  EX/MEM register-write flag.
- MEM_MemRead  out  1  EX/MEM holds a load, to HazardUnit.
- jump_MEM  out  32  MEM forwarding value: EX/MEM result for non-loads.
- RW  out  4  MEM/WB destination register.
- PW  out  32  MEM/WB writeback data (also the WB forwarding value).
- LE  out  1  MEM/WB register-file write enable.
- misalign  out  1  MEM/WB flag: the instruction was a misaligned word access.

Behaviour:
- Reset (reset==0 at an edge):
  - Both pipeline registers clear to a bubble: all control bits 0, Rd 0, data 0.
  - All outputs read 0 in the following cycle.
  - RAM contents are not cleared.
- Reset mid-operation: any store sitting in EX/MEM at that edge is discarded (no RAM write).
- EX/MEM capture: every edge, with no enable and no stall input.
  - The hazard unit stalls upstream and injects bubbles into EX.
  - EX_flush=1 captures a bubble, i.e. control bits 0; data fields are don't-care.
- Latency: an EX instruction appears on MEM_* one cycle after capture and on RW/PW/LE two cycles after.
- Address: addr = EX/MEM result[ADDR_W-1:0]; upper bits are ignored, so the RAM wraps around.
- Word alignment: a word access with addr[1:0]!=0 is misaligned.
  - Store: suppressed, RAM unchanged.
  - Load: PW=0, LE=0, misalign=1 for its single WB cycle.
- Word access bytes (big-endian): mem[addr]=bits 31:24, mem[addr+1]=23:16, mem[addr+2]=15:8, mem[addr+3]=7:0.
  - Aligned word accesses never cross 255.
- Byte access: store writes mem[addr] from store_data[7:0]; load zero-extends mem[addr].
- Store commit: RAM write happens at the edge that ends the MEM cycle (the same edge the MEM/WB register captures).
  - A load in the next cycle to the same address returns the new data.
- Load read: combinational from RAM during the MEM cycle, registered into PW.
- Stores never write back: LE = RF_enable AND NOT(store) AND NOT(misaligned load).
- jump_MEM:
  - Equals the EX/MEM result for all instructions.
  - It is invalid for loads; HazardUnit must stall on MEM_MemRead rather than forward.
- MEM_MemRead = load_store AND load in EX/MEM.
- Simultaneous EX_flush and reset: reset wins; the result is identical anyway.
- Bench preload: the RAM array is named mem, a [7:0] array [0:DEPTH-1], so benches may preload it hierarchically.

Decomposition:
- Shared package: SIZE_WORD/SIZE_BYTE constants and the bubble (zeroed) pipeline-register value.
- One sub-module: data_ram.
  - Byte array, combinational read, clocked write.
  - Size/enable inputs, big-endian packing.
- The pipeline registers stay in mem_stage.

Test Plan:
- Reset: hold reset=0 for 2 edges with a load in EX → MEM_* and RW/PW/LE/misalign all 0; preloaded RAM byte 0x10=0xAB unchanged.
- Word store then load: STR 0xDEADBEEF @0x20, next cycle LDR @0x20 Rd=3 → mem[0x20..0x23]=DE,AD,BE,EF; two cycles after the LDR, RW=3, PW=0xDEADBEEF, LE=1.
- Byte ops: STRB 0x123456C5 @0x21, then LDRB @0x21 → PW=0x000000C5; word @0x20 reads 0xDEC5BEEF.
- Misaligned: LDR @0x22 → misalign=1, LE=0, PW=0 for one cycle; STR @0x23 → RAM unchanged.
- Flush and hazard: STR @0x30 with EX_flush=1 → RAM unchanged, LE=0; LDR Rd=5 → MEM_MemRead=1, MEM_Rd=5 for exactly one cycle.
- ALU passthrough and wrap: ADD result 0x00000107, Rd=2, RF_enable=1 → jump_MEM=0x107 next cycle, PW=0x107 with LE=1 the cycle after; LDRB with address 0x1FF reads mem[0xFF].
